// File: rtl/shift_add_mul_pkg.sv
// rtl/shift_add_mul_pkg.sv - shared types and constants for the shift-add multiplier
//
// Contents:
//   mul_state_t  multiplier FSM states (IDLE, RUN, FIX, DONE)
//   MUL_WIDTH    default operand width
//   MUL_CNT_W    step counter width for the default operand width
//   mul_cnt_w()  step counter width for any operand width (must hold the value WIDTH)
package shift_add_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    localparam int MUL_WIDTH = 16;
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH) + 1;

    function automatic int mul_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_add_mul_cla4.sv
// rtl/shift_add_mul_cla4.sv - 4-bit carry-lookahead adder slice
//
// Ports:
//   a, b  [3:0]  addends
//   cin          carry in
//   sum   [3:0]  sum
//   cout         carry out
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:1] c;

    assign g = a & b;
    assign p = a ^ b;

    // All carries flattened from generate/propagate so none ripples.
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ {c[3], c[2], c[1], cin};

endmodule

// File: rtl/shift_add_mul_cla_add16.sv
// rtl/shift_add_mul_cla_add16.sv - WIDTH-bit adder built from chained 4-bit CLA slices
//
// Parameters:
//   WIDTH  adder width, multiple of 4 (16 gives the classic 4-slice chain)
// Ports:
//   a, b  [WIDTH-1:0]  addends
//   cin                carry into the lowest slice
//   sum   [WIDTH-1:0]  sum
//   cout               carry out of the highest slice
module cla_add16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / 4;

    logic [NSLICE:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        cla4 u_cla4 (
            .a   (a[4*i +: 4]),
            .b   (b[4*i +: 4]),
            .cin (carry[i]),
            .sum (sum[4*i +: 4]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[NSLICE];

endmodule

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - iterative shift-add multiplier with start/busy/done handshake
//
// Optional feature: define MUL_SIGNED_EN to add the sgn port and two's-complement mode.
// Parameters:
//   WIDTH  operand width, multiple of 4
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    request, sampled only in IDLE
//   a, b    [WIDTH-1:0]      multiplicand, multiplier (sampled on the accept edge)
//   sgn                      signed operands (MUL_SIGNED_EN only)
//   busy                     operation in progress, through the done cycle
//   done                     one-cycle result pulse
//   product [2*WIDTH-1:0]    result, held until replaced
//   ovfl                     product does not fit in WIDTH bits, held with product
module shift_add_mul
    import shift_add_mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef MUL_SIGNED_EN
    input  logic                 sgn,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ovfl
);

    localparam int CW = mul_cnt_w(WIDTH);

    mul_state_t state, state_nxt;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplr;
    logic [WIDTH-1:0]   acc_hi;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [2*WIDTH-1:0] res;
    logic               res_ovfl;
    logic               last_step;
`ifdef MUL_SIGNED_EN
    logic               neg;
    logic               sgn_q;
`endif

    // RUN spends one extra cycle with cnt == WIDTH where no step is taken;
    // that cycle gives the fixed accept-to-done latency.
    assign last_step = (cnt == CW'(WIDTH));
    assign addend    = mplr[0] ? mcand : '0;

    cla_add16 #(.WIDTH(WIDTH)) u_add (
        .a   (acc_hi),
        .b   (addend),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    // Operand conditioning and result fix-up.
    always_comb begin
        a_in     = a;
        b_in     = b;
        res      = {acc_hi, mplr};
        res_ovfl = |res[2*WIDTH-1:WIDTH];
`ifdef MUL_SIGNED_EN
        if (sgn && a[WIDTH-1]) a_in = '0 - a;
        if (sgn && b[WIDTH-1]) b_in = '0 - b;
        if (neg) res = '0 - {acc_hi, mplr};
        if (sgn_q) res_ovfl = (res[2*WIDTH-1:WIDTH] != {WIDTH{res[WIDTH-1]}});
`endif
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
`ifdef MUL_SIGNED_EN
            RUN:  if (last_step) state_nxt = FIX;
            FIX:  state_nxt = DONE;
`else
            RUN:  if (last_step) state_nxt = DONE;
`endif
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplr    <= '0;
            acc_hi  <= '0;
            cnt     <= '0;
            product <= '0;
            ovfl    <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg     <= 1'b0;
            sgn_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_in;
                        mplr   <= b_in;
                        acc_hi <= '0;
                        cnt    <= '0;
`ifdef MUL_SIGNED_EN
                        neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sgn_q  <= sgn;
`endif
                    end
                end
                RUN: begin
                    if (!last_step) begin
                        // {cout, sum, mplr} >> 1
                        acc_hi <= {cout, sum[WIDTH-1:1]};
                        mplr   <= {sum[0], mplr[WIDTH-1:1]};
                        cnt    <= cnt + CW'(1);
                    end
`ifndef MUL_SIGNED_EN
                    else begin
                        product <= res;
                        ovfl    <= res_ovfl;
                    end
`endif
                end
`ifdef MUL_SIGNED_EN
                FIX: begin
                    product <= res;
                    ovfl    <= res_ovfl;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
